// File: rtl/pa_TimingEngine.sv
// rtl/pa_TimingEngine.sv - shared state type and default sizes for the timing engine
package pa_TimingEngine;

  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_SIZE_T_ARSTFS = 8;
  localparam int DEF_SIZE_T_PLLTO  = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_DELAY    = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_ERROR    = 3'd4
  } te_state_e;

endpackage

// File: rtl/timing_engine_ch.sv
// rtl/timing_engine_ch.sv - one radio channel: input synchronisers, sequencing FSM, registered outputs
module timing_engine_ch
  import pa_TimingEngine::*;
#(
  parameter int SIZE_T_ARSTFS = DEF_SIZE_T_ARSTFS,
  parameter int SIZE_T_PLLTO  = DEF_SIZE_T_PLLTO
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     req_enable_i,
  input  logic                     req_rx_en_i,
  input  logic                     pll_settled_s_i,
  input  logic [SIZE_T_ARSTFS-1:0] t_arst_fs_i,
  input  logic [SIZE_T_PLLTO-1:0]  t_pll_timeout_i,
  output logic                     radio_enable_o,
  output logic                     radio_rx_en_o,
  output logic                     pll_timeout_err_o,
  output logic                     busy_o
);

  logic [1:0]               en_sync_q;
  logic [1:0]               rx_sync_q;
  te_state_e                state_q;
  logic                     rx_mode_q;
  logic [SIZE_T_PLLTO-1:0]  to_cnt_q;
  logic [SIZE_T_ARSTFS-1:0] dly_cnt_q;
  logic                     radio_enable_q;
  logic                     radio_rx_en_q;
  logic                     err_q;
  logic                     busy_q;

  logic en_s;
  logic rx_s;
  logic to_enabled;

  assign en_s       = en_sync_q[1];
  assign rx_s       = rx_sync_q[1];
  assign to_enabled = (t_pll_timeout_i != '0);

  // Outputs are updated alongside each transition so they always track the state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      en_sync_q      <= '0;
      rx_sync_q      <= '0;
      state_q        <= ST_IDLE;
      rx_mode_q      <= 1'b0;
      to_cnt_q       <= '0;
      dly_cnt_q      <= '0;
      radio_enable_q <= 1'b0;
      radio_rx_en_q  <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      en_sync_q <= {en_sync_q[0], req_enable_i};
      rx_sync_q <= {rx_sync_q[0], req_rx_en_i};
      case (state_q)
        ST_IDLE: begin
          if (en_s) begin
            state_q   <= ST_WAIT_PLL;
            rx_mode_q <= rx_s;
            to_cnt_q  <= t_pll_timeout_i;
            busy_q    <= 1'b1;
          end
        end
        ST_WAIT_PLL: begin
          if (!en_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (pll_settled_s_i) begin
            state_q   <= ST_DELAY;
            dly_cnt_q <= t_arst_fs_i;
          end else if (to_enabled && to_cnt_q == SIZE_T_PLLTO'(1)) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end else if (to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - SIZE_T_PLLTO'(1);
          end
        end
        ST_DELAY: begin
          if (!en_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!pll_settled_s_i) begin
            state_q  <= ST_WAIT_PLL;
            to_cnt_q <= t_pll_timeout_i;
          end else if (dly_cnt_q == '0) begin
            state_q        <= ST_ACTIVE;
            radio_enable_q <= 1'b1;
            radio_rx_en_q  <= rx_mode_q;
          end else begin
            dly_cnt_q <= dly_cnt_q - SIZE_T_ARSTFS'(1);
          end
        end
        ST_ACTIVE: begin
          if (!en_s) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            radio_enable_q <= 1'b0;
            radio_rx_en_q  <= 1'b0;
          end else if (!pll_settled_s_i) begin
            state_q        <= ST_WAIT_PLL;
            to_cnt_q       <= t_pll_timeout_i;
            radio_enable_q <= 1'b0;
            radio_rx_en_q  <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (!en_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          busy_q         <= 1'b0;
          err_q          <= 1'b0;
          radio_enable_q <= 1'b0;
          radio_rx_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign radio_enable_o    = radio_enable_q;
  assign radio_rx_en_o     = radio_rx_en_q;
  assign pll_timeout_err_o = err_q;
  assign busy_o            = busy_q;

endmodule

// File: rtl/timing_engine_mc.sv
// rtl/timing_engine_mc.sv - multi-channel radio timing engine sharing one PLL lock indication
module timing_engine_mc
  import pa_TimingEngine::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SIZE_T_ARSTFS = DEF_SIZE_T_ARSTFS,
  parameter int SIZE_T_PLLTO  = DEF_SIZE_T_PLLTO
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [NUM_CH-1:0]               reqEnable,
  input  logic [NUM_CH-1:0]               reqRxEn,
  input  logic                            pllSettled,
  input  logic [NUM_CH*SIZE_T_ARSTFS-1:0] tArstFs,
  input  logic [SIZE_T_PLLTO-1:0]         tPllTimeout,
  output logic [NUM_CH-1:0]               radioEnable,
  output logic [NUM_CH-1:0]               radioRxEn,
  output logic [NUM_CH-1:0]               pllTimeoutErr,
  output logic [NUM_CH-1:0]               busy
);

  logic [1:0] pll_sync_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pll_sync_q <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[0], pllSettled};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timing_engine_ch #(
      .SIZE_T_ARSTFS(SIZE_T_ARSTFS),
      .SIZE_T_PLLTO (SIZE_T_PLLTO)
    ) u_ch (
      .clk              (clk),
      .arst             (arst),
      .req_enable_i     (reqEnable[i]),
      .req_rx_en_i      (reqRxEn[i]),
      .pll_settled_s_i  (pll_sync_q[1]),
      .t_arst_fs_i      (tArstFs[i*SIZE_T_ARSTFS +: SIZE_T_ARSTFS]),
      .t_pll_timeout_i  (tPllTimeout),
      .radio_enable_o   (radioEnable[i]),
      .radio_rx_en_o    (radioRxEn[i]),
      .pll_timeout_err_o(pllTimeoutErr[i]),
      .busy_o           (busy[i])
    );
  end

endmodule
